// File: rtl/systolic_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_drain_if
// Purpose  : Result-stream bundle between systolic_result_drain and its
//            consumer (write-back / DMA stage). One element per transfer,
//            tagged with its row/column and an end-of-matrix marker.
// Signals  : oData  - result element
//            oValid - oData/oRow/oCol/oLast valid
//            iReady - consumer accepts when high together with oValid
//            oRow   - row index of oData
//            oCol   - column index of oData
//            oLast  - marks element [N-1][N-1]
// Modports : master - drain side (drives data/valid/tags, reads ready)
//            slave  - consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_result_drain_if #(
    parameter int RW = 160,
    parameter int IW = 3
);
    logic [RW-1:0] oData;
    logic          oValid;
    logic          iReady;
    logic [IW-1:0] oRow;
    logic [IW-1:0] oCol;
    logic          oLast;

    modport master (
        output oData,
        output oValid,
        output oRow,
        output oCol,
        output oLast,
        input  iReady
    );

    modport slave (
        input  oData,
        input  oValid,
        input  oRow,
        input  oCol,
        input  oLast,
        output iReady
    );
endinterface
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_drain
// Purpose  : Snapshots the N x N result matrix of the systolic array on the
//            rising edge of its finished level, then streams the elements out
//            row-major, one per accepted transfer, so the array is free for
//            its next operation while a slower consumer drains the results.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            iRes      - flattened matrix, element [r][c] at (r*N+c)*RW +: RW
//            iFinished - finished level from the array
//            drainIf   - result stream (master modport)
//            oBusy     - snapshot held / streaming in progress
//            oDropped  - sticky: a finish edge arrived while busy
// Revision : 1.0 - initial release
// ============================================================================
module systolic_result_drain #(
    parameter int BW = 16,
    parameter int N  = 5,
    parameter int RW = N * 2 * BW,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [N*N*RW-1:0]   iRes,
    input  wire logic                iFinished,
    systolic_result_drain_if.master  drainIf,
    output logic                     oBusy,
    output logic                     oDropped
);

    localparam int c_NN    = N * N;
    localparam int c_IDX_W = (c_NN > 1) ? $clog2(c_NN) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic                 r_finPrev;
    logic                 r_dropped;
    logic [c_IDX_W-1:0]   r_idx;
    logic [IW-1:0]        r_row;
    logic [IW-1:0]        r_col;
    logic [RW-1:0]        r_buf [c_NN];

    logic                 w_finEdge;
    logic                 w_streaming;
    logic                 w_lastElem;
    logic                 w_xfer;
    logic                 w_capture;
    logic                 w_advance;

    // finPrev resets to 0 so a finished level already high at reset release
    // still counts as a rising edge on the first clock.
    assign w_finEdge   = iFinished & ~r_finPrev;
    assign w_streaming = (r_state == S_STREAM);
    assign w_lastElem  = (r_row == IW'(N - 1)) && (r_col == IW'(N - 1));
    assign w_xfer      = w_streaming & drainIf.iReady;

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_finEdge) begin
                    w_capture   = 1'b1;
                    w_stateNext = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer) begin
                    if (w_lastElem) begin
                        w_stateNext = S_IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, edge detect, position counters, overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_finPrev <= 1'b0;
            r_dropped <= 1'b0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_finPrev <= iFinished;
            if (w_capture) begin
                r_idx <= '0;
                r_row <= '0;
                r_col <= '0;
            end else if (w_advance) begin
                // Row/column run alongside the flat index so the tags come
                // straight from registers rather than a divider.
                r_idx <= r_idx + c_IDX_W'(1);
                if (r_col == IW'(N - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + IW'(1);
                end else begin
                    r_col <= r_col + IW'(1);
                end
            end
            // A new result arriving while the snapshot is still draining is
            // discarded; the stream in flight stays intact.
            if (w_streaming && w_finEdge) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot buffer: written only on capture, contents irrelevant
    // otherwise, so it carries no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < c_NN; i++) begin
                r_buf[i] <= iRes[i*RW +: RW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only. Gating with the stream
    // state forces everything to 0 the instant reset asserts.
    // ------------------------------------------------------------------
    assign drainIf.oValid = w_streaming;
    assign drainIf.oData  = w_streaming ? r_buf[r_idx] : '0;
    assign drainIf.oRow   = w_streaming ? r_row : '0;
    assign drainIf.oCol   = w_streaming ? r_col : '0;
    assign drainIf.oLast  = w_streaming & w_lastElem;
    assign oBusy          = w_streaming;
    assign oDropped       = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_result_drain
// Purpose  : Directed self-checking bench for systolic_result_drain (N=5,
//            BW=16): basic drain, matmul values, backpressure, overrun,
//            level/back-to-back finish and asynchronous reset mid-stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_result_drain;

    localparam int BW = 16;
    localparam int N  = 5;
    localparam int RW = N * 2 * BW;
    localparam int IW = 3;
    localparam int NN = N * N;

    logic              clk = 1'b0;
    logic              rst;
    logic [NN*RW-1:0]  iRes;
    logic              iFinished;
    logic              oBusy;
    logic              oDropped;

    systolic_result_drain_if #(.RW(RW), .IW(IW)) drainIf ();

    systolic_result_drain #(
        .BW (BW),
        .N  (N)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .iRes      (iRes),
        .iFinished (iFinished),
        .drainIf   (drainIf.master),
        .oBusy     (oBusy),
        .oDropped  (oDropped)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [RW-1:0] mat  [NN];
    logic [RW-1:0] snap [NN];

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic loadMat();
        for (int i = 0; i < NN; i++) begin
            iRes[i*RW +: RW] = mat[i];
        end
    endtask

    task automatic takeSnap();
        for (int i = 0; i < NN; i++) begin
            snap[i] = mat[i];
        end
    endtask

    task automatic checkElem(input string tag, input int k);
        checkBit({tag, "_valid"}, drainIf.oValid, 1'b1);
        checkBit({tag, "_busy"}, oBusy, 1'b1);
        check({tag, "_data"}, drainIf.oData, snap[k]);
        check({tag, "_row"}, RW'(drainIf.oRow), RW'(k / N));
        check({tag, "_col"}, RW'(drainIf.oCol), RW'(k % N));
        checkBit({tag, "_last"}, drainIf.oLast, (k == NN - 1));
    endtask

    // Called at the negedge where element 0 is presented; negative
    // arguments disable the corresponding feature.
    task automatic runStream(input int stallIdx, input int stallLen,
                             input int overrunAt, input int abortAt,
                             input int dropFinAt);
        for (int k = 0; k < NN; k++) begin
            if (k == abortAt) return;
            if (k == overrunAt) begin
                iFinished = 1'b1;
                for (int i = 0; i < NN; i++) mat[i] = RW'(16'hFFFF);
                loadMat();
            end
            if (k == dropFinAt) iFinished = 1'b0;
            if (k == stallIdx) begin
                drainIf.iReady = 1'b0;
                repeat (stallLen) begin
                    @(negedge clk);
                    checkElem("stall", k);
                end
                drainIf.iReady = 1'b1;
            end
            checkElem("elem", k);
            @(negedge clk);
        end
        checkBit("end_valid", drainIf.oValid, 1'b0);
        checkBit("end_busy", oBusy, 1'b0);
        checkBit("end_last", drainIf.oLast, 1'b0);
    endtask

    task automatic pulseFinish();
        takeSnap();
        iFinished = 1'b1;
        @(negedge clk);
        iFinished = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        iFinished      = 1'b0;
        iRes           = '0;
        drainIf.iReady = 1'b0;
        #1;
        checkBit("rst_valid", drainIf.oValid, 1'b0);
        checkBit("rst_busy", oBusy, 1'b0);
        checkBit("rst_last", drainIf.oLast, 1'b0);
        checkBit("rst_dropped", oDropped, 1'b0);
        check("rst_data", drainIf.oData, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic drain: element [r][c] = r*16+c+1
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r*N+c] = RW'(r * 16 + c + 1);
        loadMat();
        drainIf.iReady = 1'b1;
        @(negedge clk);
        checkBit("idle_valid", drainIf.oValid, 1'b0);
        pulseFinish();
        check("basic_first", drainIf.oData, RW'(1));
        runStream(-1, 0, -1, -1, -1);

        // Matmul values C = A*B, A[i][j]=i*5+j, B[i][j]=i*5+j+100
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += (i * 5 + k) * (k * 5 + j + 100);
                mat[i*N+j] = RW'(acc);
            end
        loadMat();
        @(negedge clk);
        pulseFinish();
        check("mm_first", drainIf.oData, RW'(1150));
        runStream(-1, 0, -1, -1, -1);

        // Backpressure at idx 7 (element (1,2)) for 3 cycles
        for (int i = 0; i < NN; i++) mat[i] = RW'(i + 1000);
        loadMat();
        @(negedge clk);
        pulseFinish();
        runStream(7, 3, -1, -1, -1);

        // Overrun at transfer 10 with iRes changed to all 0xFFFF
        for (int i = 0; i < NN; i++) mat[i] = RW'(i * 3 + 7);
        loadMat();
        @(negedge clk);
        pulseFinish();
        runStream(-1, 0, 10, -1, -1);
        checkBit("ovr_dropped", oDropped, 1'b1);
        iFinished = 1'b0;
        @(negedge clk);
        checkBit("ovr_sticky", oDropped, 1'b1);

        // Reset clears the sticky flag
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkBit("clr_dropped", oDropped, 1'b0);

        // Level held high, dropped during the last transfer, raised again on
        // the first idle cycle: back-to-back capture
        for (int i = 0; i < NN; i++) mat[i] = RW'(i + 500);
        loadMat();
        takeSnap();
        iFinished = 1'b1;
        @(negedge clk);
        runStream(-1, 0, -1, -1, NN - 1);
        for (int i = 0; i < NN; i++) mat[i] = RW'(i + 600);
        loadMat();
        takeSnap();
        iFinished = 1'b1;
        @(negedge clk);
        checkBit("b2b_dropped", oDropped, 1'b0);
        check("b2b_first", drainIf.oData, RW'(600));
        runStream(-1, 0, -1, -1, -1);
        repeat (3) begin
            @(negedge clk);
            checkBit("level_idle", drainIf.oValid, 1'b0);
        end
        iFinished = 1'b0;

        // Asynchronous reset at idx 12
        for (int i = 0; i < NN; i++) mat[i] = RW'(i + 700);
        loadMat();
        @(negedge clk);
        pulseFinish();
        runStream(-1, 0, -1, 12, -1);
        check("pre_abort_data", drainIf.oData, RW'(712));
        #2 rst = 1'b1;
        #1;
        checkBit("async_valid", drainIf.oValid, 1'b0);
        checkBit("async_busy", oBusy, 1'b0);
        checkBit("async_last", drainIf.oLast, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkBit("post_rst_idle", drainIf.oValid, 1'b0);
        end
        rst       = 1'b1;
        iFinished = 1'b1;
        for (int i = 0; i < NN; i++) mat[i] = RW'(i + 800);
        loadMat();
        takeSnap();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        iFinished = 1'b0;
        check("rst_cap_first", drainIf.oData, RW'(800));
        runStream(-1, 0, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
